sb_tx_serializer: RTL and testbench



---
 rtl/sb_tx_serializer.sv | 204 ++++++++++++++++++++
 tb/tb_sb_tx_serializer.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_tx_serializer.sv
// Sideband transmit serializer.
// Expands a 4-bit encoded sideband message into a 64-bit message-without-data
// packet and shifts it out LSB first (1 UI per i_clk), or emits a 64 UI
// alternating clock pattern burst. Every packet or burst is followed by a
// GAP_UI idle gap before the block returns to IDLE.
//
// Ports:
//   i_clk                 serializer clock, 1 UI per cycle
//   i_rst_n               async active-low reset
//   i_sb_en               block enable; low aborts to IDLE on the next edge
//   i_start_pattern_req   level request for a 64 UI pattern burst
//   i_encoded_SB_msg      message code (1 OUT_OF_RESET, 2 DONE_REQ, 3 DONE_RESP)
//   i_tx_msg_valid        message code valid, sampled only in IDLE
//   o_sb_txdat            serial data, LSB first
//   o_sb_txclk_en         high on every UI carrying pattern or packet bits
//   o_start_pattern_done  one-cycle pulse on the last pattern UI
//   o_SB_Busy             serializer occupied; falling edge = ready
//   o_illegal_msg         one-cycle pulse for a valid carrying code 0 or >3
module sb_tx_serializer #(
  parameter int unsigned SB_MSG_WIDTH = 4,
  parameter int unsigned PKT_WIDTH    = 64,
  parameter int unsigned GAP_UI       = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sb_en,
  input  logic                    i_start_pattern_req,
  input  logic [SB_MSG_WIDTH-1:0] i_encoded_SB_msg,
  input  logic                    i_tx_msg_valid,
  output logic                    o_sb_txdat,
  output logic                    o_sb_txclk_en,
  output logic                    o_start_pattern_done,
  output logic                    o_SB_Busy,
  output logic                    o_illegal_msg
);

  localparam int unsigned CNT_W = 7;
  localparam logic [CNT_W-1:0] PKT_LAST  = CNT_W'(PKT_WIDTH - 1);
  localparam logic [CNT_W-1:0] DONE_ARM  = CNT_W'(PKT_WIDTH - 2);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_UI - 1);
  localparam logic [4:0]       MWD_OPCODE = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PATTERN,
    ST_PKT,
    ST_GAP
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PKT_WIDTH-1:0]   shreg_q, shreg_d;
  logic                   txdat_q, txdat_d;
  logic                   clken_q, clken_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   illegal_q, illegal_d;

  logic                   msg_legal;
  logic [7:0]             msg_code;
  logic [7:0]             msg_subcode;
  logic [PKT_WIDTH-1:0]   new_pkt;

  // Assemble a message-without-data packet; CP covers bits [61:0], DP is 0.
  function automatic logic [PKT_WIDTH-1:0] build_pkt(input logic [7:0] mc,
                                                     input logic [7:0] sc);
    logic [PKT_WIDTH-1:0] pkt;
    pkt         = '0;
    pkt[4:0]    = MWD_OPCODE;
    pkt[21:14]  = mc;
    pkt[39:32]  = sc;
    pkt[62]     = ^pkt[61:0];
    pkt[63]     = 1'b0;
    return pkt;
  endfunction

  // Encoded message code to msgcode/subcode lookup.
  always_comb begin
    msg_legal   = 1'b1;
    msg_code    = 8'h00;
    msg_subcode = 8'h00;
    case (i_encoded_SB_msg)
      SB_MSG_WIDTH'(1): begin msg_code = 8'h91; msg_subcode = 8'h00; end
      SB_MSG_WIDTH'(2): begin msg_code = 8'h95; msg_subcode = 8'h01; end
      SB_MSG_WIDTH'(3): begin msg_code = 8'h9A; msg_subcode = 8'h01; end
      default:          msg_legal = 1'b0;
    endcase
  end

  assign new_pkt = build_pkt(msg_code, msg_subcode);

  // State register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      txdat_q   <= 1'b0;
      clken_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      txdat_q   <= txdat_d;
      clken_q   <= clken_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state; output registers are loaded with the values that belong to
  // the UI being entered, so outputs line up with state_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    txdat_d   = 1'b0;
    clken_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = 1'b0;
    illegal_d = 1'b0;

    if (!i_sb_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      shreg_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_tx_msg_valid && msg_legal) begin
            state_d = ST_PKT;
            cnt_d   = '0;
            shreg_d = new_pkt;
            txdat_d = new_pkt[0];
            clken_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            illegal_d = i_tx_msg_valid;
            if (i_start_pattern_req) begin
              state_d = ST_PATTERN;
              cnt_d   = '0;
              txdat_d = 1'b1;
              clken_d = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end

        ST_PATTERN: begin
          busy_d = 1'b1;
          if (cnt_q == PKT_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            // Even UIs carry 1, so the next UI is 1 exactly when this one is odd.
            txdat_d = cnt_q[0];
            clken_d = 1'b1;
            done_d  = (cnt_q == DONE_ARM);
          end
        end

        ST_PKT: begin
          busy_d  = 1'b1;
          shreg_d = shreg_q >> 1;
          if (cnt_q == PKT_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            txdat_d = shreg_q[1];
            clken_d = 1'b1;
          end
        end

        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_sb_txdat           = txdat_q;
  assign o_sb_txclk_en        = clken_q;
  assign o_start_pattern_done = done_q;
  assign o_SB_Busy            = busy_q;
  assign o_illegal_msg        = illegal_q;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Self-checking bench for sb_tx_serializer.
// A queue-based reference model turns each accepted request into the list of
// per-cycle output values it should produce; every cycle the DUT outputs are
// compared with the head of that list. Directed scenarios add checks on
// captured packets, cycle positions and counts; a randomized phase follows.
module tb_sb_tx_serializer;

  typedef struct packed {
    logic busy;
    logic clken;
    logic txdat;
    logic done;
    logic illegal;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       sb_en;
  logic       req;
  logic [3:0] code;
  logic       valid;
  logic       txdat;
  logic       clken;
  logic       done;
  logic       busy;
  logic       illegal;

  int n_checks;
  int n_errors;
  int cycle;

  exp_t q[$];

  int   busy_cnt, first_busy, last_busy;
  int   clken_cnt, txdat_cnt;
  int   done_cnt, done_first;
  int   illegal_cnt, illegal_first;
  logic prev_clken;
  int   starts[$];
  bit   cap[$];

  sb_tx_serializer #(
    .SB_MSG_WIDTH(4),
    .PKT_WIDTH   (64),
    .GAP_UI      (32)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_sb_en             (sb_en),
    .i_start_pattern_req (req),
    .i_encoded_SB_msg    (code),
    .i_tx_msg_valid      (valid),
    .o_sb_txdat          (txdat),
    .o_sb_txclk_en       (clken),
    .o_start_pattern_done(done),
    .o_SB_Busy           (busy),
    .o_illegal_msg       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet contents derived from the field layout with plain arithmetic.
  function automatic logic [63:0] model_pkt(input logic [3:0] c);
    logic [63:0] mc, sc, p;
    case (c)
      4'd1:    begin mc = 64'h91; sc = 64'h00; end
      4'd2:    begin mc = 64'h95; sc = 64'h01; end
      default: begin mc = 64'h9A; sc = 64'h01; end
    endcase
    p = 64'h12 | (mc << 14) | (sc << 32);
    p = p | (64'(^p) << 62);
    return p;
  endfunction

  // 32 gap UIs plus the single idle cycle before the next acceptance.
  task automatic push_gap();
    for (int i = 0; i < 32; i++) q.push_back(5'b10000);
    q.push_back(5'b00000);
  endtask

  task automatic push_pkt(input logic [63:0] p);
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e = '0; e.busy = 1'b1; e.clken = 1'b1; e.txdat = p[i];
      q.push_back(e);
    end
    push_gap();
  endtask

  task automatic push_pattern();
    exp_t e;
    for (int i = 0; i < 64; i++) begin
      e = '0; e.busy = 1'b1; e.clken = 1'b1;
      e.txdat = ((i % 2) == 0);
      e.done  = (i == 63);
      q.push_back(e);
    end
    push_gap();
  endtask

  task automatic reset_stats();
    busy_cnt = 0; first_busy = 0; last_busy = 0;
    clken_cnt = 0; txdat_cnt = 0;
    done_cnt = 0; done_first = 0;
    illegal_cnt = 0; illegal_first = 0;
    prev_clken = 1'b0;
    starts.delete();
    cap.delete();
  endtask

  task automatic rebase();
    cycle = 1;
    reset_stats();
  endtask

  // One clock: advance the model at the edge, compare #1 later, gather stats.
  task automatic tick();
    exp_t e;
    logic ill;
    @(posedge clk);
    e   = '0;
    ill = 1'b0;
    if (!rst_n || !sb_en) begin
      q.delete();
    end else if (q.size() != 0) begin
      e = q.pop_front();
    end else begin
      if (valid && code >= 4'd1 && code <= 4'd3) begin
        push_pkt(model_pkt(code));
      end else begin
        ill = valid;
        if (req) push_pattern();
      end
      if (q.size() != 0) e = q.pop_front();
      e.illegal = ill;
    end
    #1;
    cycle++;
    chk($sformatf("out@%0d", cycle), 64'({busy, clken, txdat, done, illegal}), 64'(e));
    if (busy) begin
      busy_cnt++;
      if (first_busy == 0) first_busy = cycle;
      last_busy = cycle;
    end
    if (clken) begin
      clken_cnt++;
      cap.push_back(txdat);
      if (!prev_clken) starts.push_back(cycle);
    end
    prev_clken = clken;
    if (txdat) txdat_cnt++;
    if (done) begin
      done_cnt++;
      if (done_first == 0) done_first = cycle;
    end
    if (illegal) begin
      illegal_cnt++;
      if (illegal_first == 0) illegal_first = cycle;
    end
  endtask

  function automatic logic [63:0] cap_word(input int off);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++)
      if (off + i < cap.size()) v[i] = cap[off + i];
    return v;
  endfunction

  function automatic int start_at(input int idx);
    if (idx < starts.size()) return starts[idx];
    return -1;
  endfunction

  task automatic run_to(input int c);
    while (cycle < c) tick();
  endtask

  initial begin
    logic [63:0] w;
    n_checks = 0;
    n_errors = 0;
    cycle    = 0;
    rst_n = 1'b0; sb_en = 1'b1; req = 1'b0; code = 4'd0; valid = 1'b0;
    reset_stats();
    repeat (3) tick();
    chk("reset_outputs", 64'({busy, clken, txdat, done, illegal}), 64'd0);

    // Code 1 packet accepted at edge 10.
    #3 rst_n = 1'b1;
    rebase();
    run_to(10);
    valid = 1'b1; code = 4'd1;
    tick();
    valid = 1'b0;
    run_to(120);
    chk("t1_first_busy", 64'(first_busy), 64'd11);
    chk("t1_last_busy",  64'(last_busy),  64'd106);
    chk("t1_busy_cnt",   64'(busy_cnt),   64'd96);
    chk("t1_clken_cnt",  64'(clken_cnt),  64'd64);
    chk("t1_packet",     cap_word(0),     64'h4000_0000_0024_4012);

    // Pattern request held: two bursts, re-armed through IDLE.
    rebase();
    run_to(5);
    req = 1'b1;
    run_to(140);
    req = 1'b0;
    run_to(220);
    chk("t2a_start0",   64'(start_at(0)), 64'd6);
    chk("t2a_start1",   64'(start_at(1)), 64'd103);
    chk("t2a_done_at",  64'(done_first),  64'd69);
    chk("t2a_done_cnt", 64'(done_cnt),    64'd2);
    chk("t2a_pattern",  cap_word(0),      64'h5555_5555_5555_5555);

    // Pattern request dropped at cycle 80: single burst.
    rebase();
    run_to(5);
    req = 1'b1;
    run_to(80);
    req = 1'b0;
    run_to(250);
    chk("t2b_clken_cnt", 64'(clken_cnt), 64'd64);
    chk("t2b_done_cnt",  64'(done_cnt),  64'd1);

    // Codes 2 then 3 back-to-back, second taken on the first busy-low cycle.
    rebase();
    run_to(5);
    valid = 1'b1; code = 4'd2;
    tick();
    code = 4'd3;
    run_to(102);
    tick();
    valid = 1'b0;
    run_to(220);
    chk("t3_start1",   64'(start_at(1)), 64'd103);
    chk("t3_busy_cnt", 64'(busy_cnt),    64'd192);
    w = cap_word(0);
    chk("t3_p0_opcode",  64'(w[4:0]),   64'h12);
    chk("t3_p0_msgcode", 64'(w[21:14]), 64'h95);
    chk("t3_p0_subcode", 64'(w[39:32]), 64'h01);
    chk("t3_p0_parity",  64'(^w[62:0]), 64'd0);
    w = cap_word(64);
    chk("t3_p1_msgcode", 64'(w[21:14]), 64'h9A);
    chk("t3_p1_subcode", 64'(w[39:32]), 64'h01);
    chk("t3_p1_parity",  64'(^w[62:0]), 64'd0);

    // Valid and pattern request together: packet first, then burst.
    rebase();
    run_to(5);
    valid = 1'b1; code = 4'd1; req = 1'b1;
    tick();
    valid = 1'b0;
    run_to(110);
    req = 1'b0;
    run_to(300);
    chk("t4_start1",   64'(start_at(1)), 64'd103);
    chk("t4_packet",   cap_word(0),      64'h4000_0000_0024_4012);
    chk("t4_pattern",  cap_word(64),     64'h5555_5555_5555_5555);
    chk("t4_done_at",  64'(done_first),  64'd166);
    chk("t4_done_cnt", 64'(done_cnt),    64'd1);

    // Illegal codes 0 and 7.
    rebase();
    run_to(5);
    valid = 1'b1; code = 4'd0;
    tick();
    code = 4'd7;
    tick();
    valid = 1'b0;
    run_to(20);
    chk("t5_illegal_cnt", 64'(illegal_cnt),   64'd2);
    chk("t5_illegal_at",  64'(illegal_first), 64'd6);
    chk("t5_busy_cnt",    64'(busy_cnt),      64'd0);
    chk("t5_txdat_cnt",   64'(txdat_cnt),     64'd0);

    // Enable dropped while UI 20 of a packet is on the line.
    rebase();
    run_to(5);
    valid = 1'b1; code = 4'd3;
    tick();
    valid = 1'b0;
    run_to(26);
    sb_en = 1'b0;
    tick();
    chk("t6_busy_after_abort", 64'(busy), 64'd0);
    sb_en = 1'b1;
    run_to(140);
    chk("t6_clken_cnt", 64'(clken_cnt), 64'd21);
    chk("t6_busy_cnt",  64'(busy_cnt),  64'd21);

    // Async reset during the gap.
    rebase();
    run_to(5);
    valid = 1'b1; code = 4'd2;
    tick();
    valid = 1'b0;
    run_to(80);
    chk("t7_busy_in_gap", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t7_async_reset", 64'({busy, clken, txdat, done, illegal}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    rebase();
    run_to(3);
    req = 1'b1;
    tick();
    req = 1'b0;
    run_to(120);
    chk("t7_restart_start", 64'(start_at(0)), 64'd4);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      valid = ($urandom_range(0, 7) == 0);
      code  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 3));
      if ($urandom_range(0, 39) == 0) req = ~req;
      sb_en = ($urandom_range(0, 299) != 0);
      tick();
    end
    valid = 1'b0; req = 1'b0; sb_en = 1'b1;
    repeat (100) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
